sb_dff_pipe: RTL and testbench
==============================

// Module: sb_dff_pipe
// PURPOSE
//   Parametrised elastic register pipeline: the next generation of the SB_DFF/SB_DFFE/SB_DFFSR family.
//   Moves a WIDTH-bit word through DEPTH register stages under valid/ready flow control.
//   Bubbles are collapsed and backpressure is absorbed stage by stage.
//   Sits between fabric datapaths wherever a retimed, stallable register chain is needed.
// PARAMETERS
//   WIDTH        8     data width in bits, >=1
//   DEPTH        3     number of register stages, >=1
//   RESET_VALUE  0     WIDTH-bit value loaded into every data stage on reset
// PORTS
//   C          in   1                    clock, rising edge
//   R          in   1                    synchronous reset, active-high
//   E          in   1                    global clock enable; 0 freezes all state
//   FLUSH      in   1                    synchronous clear of all valid bits
//   IN_DATA    in   WIDTH                write data
//   IN_VALID   in   1                    write request
//   IN_READY   out  1                    pipeline accepts IN_DATA this cycle
//   OUT_DATA   out  WIDTH                data of last stage
//   OUT_VALID  out  1                    last stage holds a word
//   OUT_READY  in   1                    consumer takes OUT_DATA this cycle
//   OCCUPANCY  out  $clog2(DEPTH+1)      present only with SB_DFF_PIPE_OCC_EN
// BEHAVIOUR
//   - Clock and reset: one clock C. Reset R is synchronous, active-high, and has priority over all inputs.
//   - Reset values: all vld[i]=0; all data stages=RESET_VALUE; OUT_VALID=0; OUT_DATA=RESET_VALUE;
//     IN_READY=0 while R=1; OCCUPANCY=0.
//   - Stage state: stage i (0..DEPTH-1) holds vld[i] and dat[i].
//     Stage 0 is the input stage; stage DEPTH-1 drives the OUT_* ports.
//   - Advance chain (combinational):
//     adv[DEPTH-1] = vld[DEPTH-1] & OUT_READY.
//     For i<DEPTH-1: adv[i] = vld[i] & (~vld[i+1] | adv[i+1]).
//     Stage i+1 loads from stage i when vld[i] & (~vld[i+1] | adv[i+1]).
//   - Input handshake: IN_READY = E & ~FLUSH & ~R & (~vld[0] | adv[0]).
//     A transfer occurs when IN_VALID & IN_READY.
//   - Output handshake: OUT_VALID = E & vld[DEPTH-1].
//     A transfer occurs when OUT_VALID & OUT_READY.
//   - Latency and throughput: with no stall, a word accepted at edge n appears on OUT_* after edge n+DEPTH-1,
//     i.e. DEPTH cycles from IN_VALID to OUT_VALID. Sustained throughput is 1 word per cycle.
//   - Bubble collapse: a word advances into any empty downstream stage even while the output is stalled.
//   - Full: all vld=1 and OUT_READY=0 -> IN_READY=0 and no state changes.
//     Full with OUT_READY=1 -> simultaneous read and write, no bubble inserted.
//   - Empty: all vld=0 -> OUT_VALID=0. OUT_DATA holds the last value; it is not re-zeroed.
//   - Data hold: data registers load only when their stage loads (no toggling on bubbles).
//   - E=0: all registers hold; IN_READY=0 and OUT_VALID=0, so no transfer can occur.
//   - FLUSH=1 (with R=0): next edge clears all vld. Data registers are untouched.
//     A word presented on the output is not counted as transferred. Input is refused.
//     FLUSH acts even when E=0.
//   - Priority: R > FLUSH > E > normal operation.
//   - Reset mid-stream: all in-flight words are discarded at the reset edge.
//   - DEPTH=1: a single stage; full/empty rules above still apply.
// CONFIGURATION
//   - Macro: SB_DFF_PIPE_OCC_EN.
//   - Defined: OCCUPANCY port is present and registered.
//     It equals the count of vld bits after each edge (0..DEPTH), updated by +1/-1/0 per transfer.
//     Reset and FLUSH set it to 0.
//   - Undefined: OCCUPANCY port and its counter are absent; all other behaviour is identical.
// TESTING
//   1. Reset: WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5; R=1 for 2 cycles
//      -> OUT_VALID=0, OUT_DATA=8'hA5, IN_READY=0, OCCUPANCY=0.
//   2. Streaming: E=1, OUT_READY=1; push 8'h01..8'h10 on consecutive cycles
//      -> 8'h01 valid 3 cycles after first accept; all 16 words in order, no gaps, IN_READY stays 1.
//   3. Backpressure: OUT_READY=0; push 8'h11,8'h22,8'h33,8'h44
//      -> first 3 accepted, IN_READY=0 on 4th, OCCUPANCY=3.
//      Then OUT_READY=1 -> 11,22,33,44 delivered on consecutive cycles.
//   4. Simultaneous full read/write: pipe full, OUT_READY=1, IN_VALID=1 each cycle
//      -> one word in and one out per cycle, OCCUPANCY stays 3.
//   5. Freeze and flush: E=0 for 5 cycles with 2 words inside -> no output, state held.
//      Then FLUSH=1 for 1 cycle -> OUT_VALID=0, OCCUPANCY=0, OUT_DATA unchanged.
//   6. Reset mid-stream: R=1 while 2 words in flight and IN_VALID=1
//      -> nothing delivered, all stages RESET_VALUE, first post-reset word emerges after 3 cycles.

Source files
------------

// File: rtl/sb_dff_pipe.sv
// -----------------------------------------------------------------------------
// sb_dff_pipe
//
// Elastic register pipeline. A WIDTH-bit word moves through DEPTH register
// stages under valid/ready flow control. Bubbles collapse (a word always moves
// into an empty downstream stage), and backpressure is absorbed stage by stage.
//
// Parameters
//   WIDTH        data width in bits (>= 1)
//   DEPTH        number of register stages (>= 1)
//   RESET_VALUE  value loaded into every data stage on reset
//
// Ports
//   C          in   clock, rising edge
//   R          in   synchronous reset, active-high, highest priority
//   E          in   global clock enable; 0 freezes all state
//   FLUSH      in   synchronous clear of all valid bits (acts even when E=0)
//   IN_DATA    in   write data
//   IN_VALID   in   write request
//   IN_READY   out  pipeline accepts IN_DATA this cycle
//   OUT_DATA   out  data of the last stage
//   OUT_VALID  out  last stage holds a word
//   OUT_READY  in   consumer takes OUT_DATA this cycle
//   OCCUPANCY  out  number of valid stages; present only when the macro
//                   SB_DFF_PIPE_OCC_EN is defined
//
// Build option
//   SB_DFF_PIPE_OCC_EN  adds the registered OCCUPANCY counter and port.
// -----------------------------------------------------------------------------
module sb_dff_pipe #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                         C,
    input  logic                         R,
    input  logic                         E,
    input  logic                         FLUSH,
    input  logic [WIDTH-1:0]             IN_DATA,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [WIDTH-1:0]             OUT_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY
`ifdef SB_DFF_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   OCCUPANCY
`endif
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];

    logic [DEPTH-1:0] adv_s;     // stage i hands its word downstream (or out)
    logic [DEPTH-1:0] load_s;    // stage i captures a new word
    logic             in_fire_s;

    // Advance chain. A stage can move when everything above it is either
    // draining out of the pipe or contains a hole somewhere, so the recursive
    // definition reduces to "OUT_READY or any empty stage above". Computing it
    // as a running OR keeps the logic free of a self-referencing vector.
    always_comb begin
        logic room_v;
        room_v = OUT_READY;
        adv_s  = {DEPTH{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv_s[i] = vld_q[i] & room_v;
            room_v   = room_v | ~vld_q[i];
        end
    end

    assign IN_READY  = E & ~FLUSH & ~R & (~vld_q[0] | adv_s[0]);
    assign OUT_VALID = E & vld_q[DEPTH-1];
    assign OUT_DATA  = dat_q[DEPTH-1];
    assign in_fire_s = IN_VALID & IN_READY;

    // Per-stage load enables: stage 0 loads on an input transfer, every other
    // stage loads exactly when its upstream neighbour advances.
    always_comb begin
        load_s    = {DEPTH{1'b0}};
        load_s[0] = in_fire_s;
        for (int i = 1; i < DEPTH; i++) begin
            load_s[i] = adv_s[i-1];
        end
    end

    // Next-state for valid bits and data. FLUSH wins over E; data registers
    // only change on a load so bubbles never toggle them.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (FLUSH) begin
            vld_d = {DEPTH{1'b0}};
        end else if (E) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_d[i] = (vld_q[i] & ~adv_s[i]) | load_s[i];
            end
            if (load_s[0]) begin
                dat_d[0] = IN_DATA;
            end else begin
                dat_d[0] = dat_q[0];
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (load_s[i]) begin
                    dat_d[i] = dat_q[i-1];
                end else begin
                    dat_d[i] = dat_q[i];
                end
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge C) begin
        if (R) begin
            vld_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= RESET_VALUE;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

`ifdef SB_DFF_PIPE_OCC_EN
    localparam int OW = $clog2(DEPTH + 1);

    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;
    logic          out_fire_s;

    // A word sitting on the output during FLUSH or R is discarded, not sent.
    assign out_fire_s = OUT_VALID & OUT_READY & ~FLUSH & ~R;

    // Occupancy tracks transfers: +1 on input only, -1 on output only.
    always_comb begin
        occ_d = occ_q;
        if (FLUSH) begin
            occ_d = {OW{1'b0}};
        end else if (in_fire_s & ~out_fire_s) begin
            occ_d = occ_q + OW'(1'b1);
        end else if (~in_fire_s & out_fire_s) begin
            occ_d = occ_q - OW'(1'b1);
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy counter register.
    always_ff @(posedge C) begin
        if (R) begin
            occ_q <= {OW{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    assign OCCUPANCY = occ_q;
`endif

endmodule

// File: tb/tb_sb_dff_pipe.sv
module tb_sb_dff_pipe;
    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'hA5;

    logic       C = 1'b0;
    logic       R = 1'b1, E = 1'b1, FLUSH = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
    logic [7:0] IN_DATA = 8'h00;
    logic       IN_READY, OUT_VALID;
    logic [7:0] OUT_DATA;
`ifdef SB_DFF_PIPE_OCC_EN
    logic [1:0] OCCUPANCY;
`endif

    sb_dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
        .C(C), .R(R), .E(E), .FLUSH(FLUSH),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
`ifdef SB_DFF_PIPE_OCC_EN
        , .OCCUPANCY(OCCUPANCY)
`endif
    );

    always #5 C = ~C;

    int total = 0;
    int bad   = 0;

    // Reference model: ordered list of words in flight with their stage index.
    logic [7:0] m_dat[$];
    int         m_pos[$];
    logic [7:0] m_out_data = RV;

    function automatic bit m_in_ready();
        return !R && E && !FLUSH && (OUT_READY || m_dat.size() < DEPTH);
    endfunction

    function automatic bit m_out_valid();
        return E && m_dat.size() > 0 && m_pos[0] == DEPTH - 1;
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    task automatic tick();
        bit         inf, outf;
        logic [7:0] d;
        int         lim, np;
        inf  = IN_VALID && m_in_ready();
        outf = !R && !FLUSH && m_out_valid() && OUT_READY;
        d    = IN_DATA;
        @(posedge C);
        #1;
        if (R) begin
            m_dat.delete(); m_pos.delete(); m_out_data = RV;
        end else if (FLUSH) begin
            m_dat.delete(); m_pos.delete();
        end else if (E) begin
            if (outf) begin
                void'(m_dat.pop_front()); void'(m_pos.pop_front());
            end
            lim = DEPTH;
            for (int k = 0; k < m_pos.size(); k++) begin
                np = m_pos[k] + 1;
                if (np > lim - 1) np = lim - 1;
                m_pos[k] = np;
                lim = np;
            end
            if (inf) begin
                m_dat.push_back(d); m_pos.push_back(0);
            end
        end
        if (m_dat.size() > 0 && m_pos[0] == DEPTH - 1) m_out_data = m_dat[0];
    endtask

    task automatic test_reset();
        R = 1'b1; E = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b1; IN_DATA = 8'h5A; OUT_READY = 1'b1;
        @(negedge C);
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL reset_in_ready0 got=%b want=0", IN_READY); end
        tick();
        @(negedge C);
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", OUT_VALID); end
        total++; if (OUT_DATA !== 8'hA5) begin bad++; $display("FAIL reset_out_data got=%h want=a5", OUT_DATA); end
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL reset_in_ready1 got=%b want=0", IN_READY); end
        tick();
        R = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        @(negedge C);
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%b want=0", OUT_VALID); end
        total++; if (OUT_DATA !== 8'hA5) begin bad++; $display("FAIL post_reset_out_data got=%h want=a5", OUT_DATA); end
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", IN_READY); end
`ifdef SB_DFF_PIPE_OCC_EN
        total++; if (OCCUPANCY !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", OCCUPANCY); end
`endif
        tick();
    endtask

    task automatic test_streaming();
        logic [7:0] got[$];
        int         cyc[$];
        E = 1'b1; OUT_READY = 1'b1; FLUSH = 1'b0; R = 1'b0;
        for (int c = 0; c < 24; c++) begin
            IN_VALID = (c < 16);
            IN_DATA  = (c < 16) ? 8'(c + 1) : 8'($urandom);
            @(negedge C);
            total++; if (OUT_VALID !== m_out_valid()) begin bad++; $display("FAIL stream_out_valid c=%0d got=%b want=%b", c, OUT_VALID, m_out_valid()); end
            total++; if (OUT_DATA !== m_out_data) begin bad++; $display("FAIL stream_out_data c=%0d got=%h want=%h", c, OUT_DATA, m_out_data); end
            if (c < 16) begin
                total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL stream_in_ready c=%0d got=%b want=1", c, IN_READY); end
            end
            if (OUT_VALID === 1'b1) begin got.push_back(OUT_DATA); cyc.push_back(c); end
            tick();
        end
        total++; if (got.size() != 16) begin bad++; $display("FAIL stream_count got=%0d want=16", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] !== 8'(i + 1)) begin bad++; $display("FAIL stream_order i=%0d got=%h want=%h", i, got[i], 8'(i + 1)); end
            total++; if (cyc[i] != 3 + i) begin bad++; $display("FAIL stream_timing i=%0d got=%0d want=%0d", i, cyc[i], 3 + i); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w[4];
        logic [7:0] got[$];
        int         cyc[$];
        int         idx;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        idx = 0;
        OUT_READY = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) OUT_READY = 1'b1;
            IN_VALID = (idx < 4);
            IN_DATA  = w[idx % 4];
            @(negedge C);
            total++; if (OUT_VALID !== m_out_valid()) begin bad++; $display("FAIL bp_out_valid c=%0d got=%b want=%b", c, OUT_VALID, m_out_valid()); end
            total++; if (OUT_DATA !== m_out_data) begin bad++; $display("FAIL bp_out_data c=%0d got=%h want=%h", c, OUT_DATA, m_out_data); end
            total++; if (IN_READY !== m_in_ready()) begin bad++; $display("FAIL bp_in_ready_model c=%0d got=%b want=%b", c, IN_READY, m_in_ready()); end
            if (c < 4) begin
                total++; if (IN_READY !== (c < 3)) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b want=%b", c, IN_READY, (c < 3)); end
            end
`ifdef SB_DFF_PIPE_OCC_EN
            if (c == 4) begin
                total++; if (OCCUPANCY !== 2'd3) begin bad++; $display("FAIL bp_occ got=%0d want=3", OCCUPANCY); end
            end
`endif
            if (OUT_VALID === 1'b1 && OUT_READY) begin got.push_back(OUT_DATA); cyc.push_back(c); end
            if (IN_VALID && IN_READY === 1'b1) idx++;
            tick();
        end
        total++; if (got.size() != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] !== w[i % 4]) begin bad++; $display("FAIL bp_order i=%0d got=%h want=%h", i, got[i], w[i % 4]); end
            total++; if (cyc[i] != 4 + i) begin bad++; $display("FAIL bp_timing i=%0d got=%0d want=%0d", i, cyc[i], 4 + i); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        IN_VALID = 1'b1; OUT_READY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            IN_DATA = 8'($urandom);
            exp_q.push_back(IN_DATA);
            tick();
        end
        OUT_READY = 1'b1;
        for (int c = 0; c < 12; c++) begin
            IN_VALID = (c < 8);
            IN_DATA  = 8'($urandom);
            @(negedge C);
            total++; if (OUT_VALID !== m_out_valid()) begin bad++; $display("FAIL b2b_out_valid c=%0d got=%b want=%b", c, OUT_VALID, m_out_valid()); end
            total++; if (OUT_DATA !== m_out_data) begin bad++; $display("FAIL b2b_out_data c=%0d got=%h want=%h", c, OUT_DATA, m_out_data); end
            if (c < 8) begin
                total++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b1) begin bad++; $display("FAIL b2b_full_rw c=%0d got=%b%b want=11", c, IN_READY, OUT_VALID); end
`ifdef SB_DFF_PIPE_OCC_EN
                total++; if (OCCUPANCY !== 2'd3) begin bad++; $display("FAIL b2b_occ c=%0d got=%0d want=3", c, OCCUPANCY); end
`endif
            end
            if (OUT_VALID === 1'b1) begin
                total++; if (exp_q.size() == 0 || OUT_DATA !== exp_q[0]) begin bad++; $display("FAIL b2b_scoreboard c=%0d got=%h", c, OUT_DATA); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (IN_VALID && IN_READY === 1'b1) exp_q.push_back(IN_DATA);
            tick();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain got=%0d left want=0", exp_q.size()); end
    endtask

    task automatic test_freeze_flush();
        OUT_READY = 1'b0; E = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 8'h3C; tick();
        IN_DATA = 8'hC3; tick();
        IN_VALID = 1'b0; tick();
        E = 1'b0; OUT_READY = 1'b1;
        for (int c = 0; c < 5; c++) begin
            IN_VALID = 1'b1; IN_DATA = 8'($urandom);
            @(negedge C);
            total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL freeze_out_valid c=%0d got=%b want=0", c, OUT_VALID); end
            total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL freeze_in_ready c=%0d got=%b want=0", c, IN_READY); end
            total++; if (OUT_DATA !== 8'h3C) begin bad++; $display("FAIL freeze_out_data c=%0d got=%h want=3c", c, OUT_DATA); end
            tick();
        end
        E = 1'b1; OUT_READY = 1'b0; IN_VALID = 1'b0;
        @(negedge C);
        total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL freeze_held_valid got=%b want=1", OUT_VALID); end
`ifdef SB_DFF_PIPE_OCC_EN
        total++; if (OCCUPANCY !== 2'd2) begin bad++; $display("FAIL freeze_occ got=%0d want=2", OCCUPANCY); end
`endif
        tick();
        E = 1'b0; FLUSH = 1'b1; OUT_READY = 1'b1; IN_VALID = 1'b1;
        @(negedge C);
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", IN_READY); end
        tick();
        FLUSH = 1'b0; E = 1'b1; IN_VALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge C);
            total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL flush_out_valid c=%0d got=%b want=0", c, OUT_VALID); end
            total++; if (OUT_DATA !== 8'h3C) begin bad++; $display("FAIL flush_out_data c=%0d got=%h want=3c", c, OUT_DATA); end
`ifdef SB_DFF_PIPE_OCC_EN
            total++; if (OCCUPANCY !== 2'd0) begin bad++; $display("FAIL flush_occ c=%0d got=%0d want=0", c, OCCUPANCY); end
`endif
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] got[$];
        int         cyc[$];
        E = 1'b1; OUT_READY = 1'b1;
        for (int c = 0; c < 10; c++) begin
            R        = (c == 2);
            IN_VALID = (c <= 3);
            IN_DATA  = (c == 0) ? 8'h77 : (c == 1) ? 8'h88 : (c == 2) ? 8'h99 : 8'h5E;
            @(negedge C);
            total++; if (OUT_VALID !== m_out_valid()) begin bad++; $display("FAIL mid_out_valid c=%0d got=%b want=%b", c, OUT_VALID, m_out_valid()); end
            total++; if (OUT_DATA !== m_out_data) begin bad++; $display("FAIL mid_out_data c=%0d got=%h want=%h", c, OUT_DATA, m_out_data); end
            if (c == 3) begin
                total++; if (OUT_DATA !== 8'hA5) begin bad++; $display("FAIL mid_reset_data got=%h want=a5", OUT_DATA); end
            end
            if (OUT_VALID === 1'b1) begin got.push_back(OUT_DATA); cyc.push_back(c); end
            tick();
        end
        R = 1'b0;
        total++; if (got.size() != 1 || got[0] !== 8'h5E || cyc[0] != 6) begin
            bad++; $display("FAIL mid_delivery got_count=%0d want one word 5e at cycle 6", got.size());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            R         = ($urandom_range(0, 59) == 0);
            FLUSH     = ($urandom_range(0, 39) == 0);
            E         = ($urandom_range(0, 7) != 0);
            IN_VALID  = $urandom_range(0, 1);
            OUT_READY = ($urandom_range(0, 3) != 0);
            IN_DATA   = 8'($urandom);
            @(negedge C);
            total++; if (OUT_VALID !== m_out_valid()) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%b want=%b", c, OUT_VALID, m_out_valid()); end
            total++; if (IN_READY !== m_in_ready()) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b want=%b", c, IN_READY, m_in_ready()); end
            total++; if (OUT_DATA !== m_out_data) begin bad++; $display("FAIL rnd_out_data c=%0d got=%h want=%h", c, OUT_DATA, m_out_data); end
`ifdef SB_DFF_PIPE_OCC_EN
            total++; if (OCCUPANCY !== 2'(m_dat.size())) begin bad++; $display("FAIL rnd_occ c=%0d got=%0d want=%0d", c, OCCUPANCY, m_dat.size()); end
`endif
            tick();
        end
        R = 1'b0; FLUSH = 1'b0; E = 1'b1;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_back_to_back();
        test_freeze_flush();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
